// File: rtl/proximity_pkg.sv
// ============================================================================
// Module  : proximity_pkg
// Purpose : Shared types, widths, default thresholds and the zone
//           classification helper for the proximity datapath.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package proximity_pkg;

  // Zone encoding is visible on LEDs, so the values are fixed.
  typedef enum logic [1:0] {
    ZONE_FAR   = 2'd0,
    ZONE_NEAR  = 2'd1,
    ZONE_CLOSE = 2'd2,
    ZONE_NONE  = 2'd3
  } zone_t;

  localparam int RAW_W = 22;  // echo width in clock cycles
  localparam int CM_W  = 9;   // distance in cm (0..400)
  localparam int SUM_W = 11;  // sum of four CM_W values

  localparam int C_DEF_CYCLES_PER_CM = 2900;
  localparam int C_DEF_MAX_CM        = 400;
  localparam int C_DEF_NEAR_CM       = 50;
  localparam int C_DEF_CLOSE_CM      = 20;
  localparam int C_DEF_HYST_CM       = 5;
  localparam int C_DEF_STALE_CYCLES  = 25_000_000;

  // Entry thresholds are strict "<"; exits need the hysteresis margin on top.
  function automatic zone_t next_zone(
    input zone_t           cur,
    input logic [CM_W-1:0] avg,
    input logic [CM_W-1:0] near_th,
    input logic [CM_W-1:0] close_th,
    input logic [CM_W-1:0] near_exit,
    input logic [CM_W-1:0] close_exit
  );
    zone_t nz;
    case (cur)
      ZONE_NEAR: begin
        if (avg < close_th)        nz = ZONE_CLOSE;
        else if (avg >= near_exit) nz = ZONE_FAR;
        else                       nz = ZONE_NEAR;
      end
      ZONE_CLOSE: begin
        if (avg >= near_exit)       nz = ZONE_FAR;
        else if (avg >= close_exit) nz = ZONE_NEAR;
        else                        nz = ZONE_CLOSE;
      end
      default: begin  // FAR or NONE
        if (avg < close_th)      nz = ZONE_CLOSE;
        else if (avg < near_th)  nz = ZONE_NEAR;
        else                     nz = ZONE_FAR;
      end
    endcase
    return nz;
  endfunction

endpackage

`default_nettype wire

// File: rtl/distance_tracker_if.sv
// ============================================================================
// Module  : distance_tracker_if
// Purpose : Sample input and result output bundle of distance_tracker.
//           slave = tracker side, master = sensor/consumer side.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface distance_tracker_if;
  import proximity_pkg::*;

  logic             sample_valid;
  logic [RAW_W-1:0] distance_raw;
  logic [CM_W-1:0]  dist_cm;
  logic             dist_valid;
  zone_t            zone;
  logic             stale;
  logic             busy;

  modport master (
    output sample_valid, distance_raw,
    input  dist_cm, dist_valid, zone, stale, busy
  );

  modport slave (
    input  sample_valid, distance_raw,
    output dist_cm, dist_valid, zone, stale, busy
  );

endinterface

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
// Module  : seq_divider
// Purpose : Unsigned restoring divider, one quotient bit per cycle.
//           start loads the operands; done is high during the final
//           iteration, so quotient is valid from the following cycle on.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider #(
  parameter int DIVIDEND_W = 22,
  parameter int DIVISOR_W  = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient
);

  localparam int              CNT_W     = $clog2(DIVIDEND_W);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIVIDEND_W - 1);

  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  run_q, run_d;
  logic [DIVISOR_W:0]    rem_shift;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // The dividend register doubles as the quotient register.
  always_comb begin
    rem_shift = {rem_q, quo_q[DIVIDEND_W-1]};
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    run_d     = run_q;
    if (start) begin
      rem_d = '0;
      quo_d = dividend;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      if (rem_shift >= {1'b0, divisor}) begin
        rem_d = DIVISOR_W'(rem_shift - {1'b0, divisor});
        quo_d = {quo_q[DIVIDEND_W-2:0], 1'b1};
      end else begin
        // No subtraction means rem_shift < divisor, so it fits DIVISOR_W bits.
        rem_d = rem_shift[DIVISOR_W-1:0];
        quo_d = {quo_q[DIVIDEND_W-2:0], 1'b0};
      end
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == LAST_ITER) run_d = 1'b0;
    end
  end

  // Iteration state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign done     = run_q && (cnt_q == LAST_ITER);
  assign quotient = quo_q;

endmodule

`default_nettype wire

// File: rtl/distance_tracker.sv
// ============================================================================
// Module  : distance_tracker
// Purpose : Converts echo widths to cm, smooths them with a 4-sample moving
//           average, classifies zones with hysteresis and flags stale data.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module distance_tracker
  import proximity_pkg::*;
#(
  parameter int CYCLES_PER_CM = C_DEF_CYCLES_PER_CM,
  parameter int MAX_CM        = C_DEF_MAX_CM,
  parameter int NEAR_CM       = C_DEF_NEAR_CM,
  parameter int CLOSE_CM      = C_DEF_CLOSE_CM,
  parameter int HYST_CM       = C_DEF_HYST_CM,
  parameter int STALE_CYCLES  = C_DEF_STALE_CYCLES
) (
  input logic              clk,
  input logic              rst_n,
  distance_tracker_if.slave bus
);

  localparam int DIVISOR_W = $clog2(CYCLES_PER_CM + 1);
  localparam int TIMER_W   = $clog2(STALE_CYCLES + 1);

  localparam logic [DIVISOR_W-1:0] C_DIVISOR    = DIVISOR_W'(CYCLES_PER_CM);
  localparam logic [RAW_W-1:0]     C_MAX_RAW    = RAW_W'(MAX_CM);
  localparam logic [CM_W-1:0]      C_MAX_CM     = CM_W'(MAX_CM);
  localparam logic [CM_W-1:0]      C_NEAR_TH    = CM_W'(NEAR_CM);
  localparam logic [CM_W-1:0]      C_CLOSE_TH   = CM_W'(CLOSE_CM);
  localparam logic [CM_W-1:0]      C_NEAR_EXIT  = CM_W'(NEAR_CM + HYST_CM);
  localparam logic [CM_W-1:0]      C_CLOSE_EXIT = CM_W'(CLOSE_CM + HYST_CM);
  localparam logic [TIMER_W-1:0]   C_STALE      = TIMER_W'(STALE_CYCLES);
  localparam logic [TIMER_W-1:0]   C_STALE_M1   = TIMER_W'(STALE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_AVG  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               busy_q, busy_d;
  logic [CM_W-1:0]    dist_cm_q, dist_cm_d;
  logic               dist_valid_q, dist_valid_d;
  zone_t              zone_q, zone_d;
  logic               stale_q, stale_d;
  logic               primed_q, primed_d;
  logic [CM_W-1:0]    ring_q [4];
  logic [CM_W-1:0]    ring_d [4];
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [1:0]         wr_ptr_q, wr_ptr_d;
  logic [TIMER_W-1:0] timer_q, timer_d;

  logic               div_start;
  logic               div_done;
  logic [RAW_W-1:0]   div_quo;
  logic [CM_W-1:0]    cm_sat;
  logic [SUM_W-1:0]   new_sum;
  logic               timeout;

  // Samples are accepted only in IDLE; the divider latches the raw value itself.
  assign div_start = (state_q == S_IDLE) && bus.sample_valid;

  seq_divider #(
    .DIVIDEND_W (RAW_W),
    .DIVISOR_W  (DIVISOR_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (bus.distance_raw),
    .divisor  (C_DIVISOR),
    .done     (div_done),
    .quotient (div_quo)
  );

  // Saturate the quotient and form the new running sum (priming fills all four).
  always_comb begin
    cm_sat = (div_quo > C_MAX_RAW) ? C_MAX_CM : div_quo[CM_W-1:0];
    if (primed_q)
      new_sum = sum_q - SUM_W'(ring_q[wr_ptr_q]) + SUM_W'(cm_sat);
    else
      new_sum = {cm_sat, 2'b00};
  end

  // Conversion FSM, averager, zone update and stale timer.
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    dist_cm_d    = dist_cm_q;
    dist_valid_d = 1'b0;
    zone_d       = zone_q;
    stale_d      = stale_q;
    primed_d     = primed_q;
    ring_d       = ring_q;
    sum_d        = sum_q;
    wr_ptr_d     = wr_ptr_q;

    // Any strobe restarts the timer, even one ignored while busy.
    if (bus.sample_valid)        timer_d = '0;
    else if (timer_q != C_STALE) timer_d = timer_q + TIMER_W'(1);
    else                         timer_d = timer_q;
    timeout = !bus.sample_valid && (timer_q == C_STALE_M1);

    case (state_q)
      S_IDLE: begin
        if (bus.sample_valid) begin
          state_d = S_DIV;
          busy_d  = 1'b1;
        end
      end
      S_DIV: begin
        if (div_done) state_d = S_AVG;
      end
      S_AVG: begin
        if (primed_q) begin
          ring_d[wr_ptr_q] = cm_sat;
          wr_ptr_d         = wr_ptr_q + 2'd1;
        end else begin
          for (int i = 0; i < 4; i++) ring_d[i] = cm_sat;
          primed_d = 1'b1;
        end
        sum_d        = new_sum;
        dist_cm_d    = new_sum[SUM_W-1:2];
        zone_d       = next_zone(zone_q, new_sum[SUM_W-1:2], C_NEAR_TH,
                                 C_CLOSE_TH, C_NEAR_EXIT, C_CLOSE_EXIT);
        stale_d      = 1'b0;
        dist_valid_d = 1'b1;
        state_d      = S_OUT;
      end
      S_OUT: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    // A result being published beats a simultaneous timeout.
    if (timeout) begin
      if (state_q == S_AVG) begin
        timer_d = '0;
      end else begin
        stale_d  = 1'b1;
        zone_d   = ZONE_NONE;
        primed_d = 1'b0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      dist_cm_q    <= '0;
      dist_valid_q <= 1'b0;
      zone_q       <= ZONE_NONE;
      stale_q      <= 1'b1;
      primed_q     <= 1'b0;
      for (int i = 0; i < 4; i++) ring_q[i] <= '0;
      sum_q        <= '0;
      wr_ptr_q     <= '0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      dist_cm_q    <= dist_cm_d;
      dist_valid_q <= dist_valid_d;
      zone_q       <= zone_d;
      stale_q      <= stale_d;
      primed_q     <= primed_d;
      for (int i = 0; i < 4; i++) ring_q[i] <= ring_d[i];
      sum_q        <= sum_d;
      wr_ptr_q     <= wr_ptr_d;
      timer_q      <= timer_d;
    end
  end

  assign bus.dist_cm    = dist_cm_q;
  assign bus.dist_valid = dist_valid_q;
  assign bus.zone       = zone_q;
  assign bus.stale      = stale_q;
  assign bus.busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_distance_tracker.sv
// ============================================================================
// Module  : tb_distance_tracker
// Purpose : Directed self-checking bench for distance_tracker.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_distance_tracker;
  import proximity_pkg::*;

  localparam int C_STALE = 300;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  distance_tracker_if ifc ();

  distance_tracker #(
    .STALE_CYCLES (C_STALE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ifc.sample_valid = 1'b0;
    ifc.distance_raw = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Drive one strobe during "cycle 0"; returns at the negedge of cycle 1.
  task automatic send(input logic [RAW_W-1:0] raw);
    @(negedge clk);
    ifc.sample_valid = 1'b1;
    ifc.distance_raw = raw;
    @(negedge clk);
    ifc.sample_valid = 1'b0;
  endtask

  // Full conversion with latency, busy window and result checks.
  task automatic run(input string tag, input logic [RAW_W-1:0] raw,
                     input int exp_cm, input zone_t exp_zone);
    int cyc;
    send(raw);
    cyc = 1;
    check({tag, ".busy_c1"}, 32'(ifc.busy), 32'd1);
    while (!ifc.dist_valid && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ".latency"}, 32'(cyc), 32'd24);
    check({tag, ".dist_cm"}, 32'(ifc.dist_cm), 32'(exp_cm));
    check({tag, ".zone"}, 32'(ifc.zone), 32'(exp_zone));
    check({tag, ".stale"}, 32'(ifc.stale), 32'd0);
    check({tag, ".busy_c24"}, 32'(ifc.busy), 32'd1);
    @(negedge clk);
    check({tag, ".valid_c25"}, 32'(ifc.dist_valid), 32'd0);
    check({tag, ".busy_c25"}, 32'(ifc.busy), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".dist_cm"}, 32'(ifc.dist_cm), 32'd0);
    check({tag, ".dist_valid"}, 32'(ifc.dist_valid), 32'd0);
    check({tag, ".zone"}, 32'(ifc.zone), 32'd3);
    check({tag, ".stale"}, 32'(ifc.stale), 32'd1);
    check({tag, ".busy"}, 32'(ifc.busy), 32'd0);
  endtask

  initial begin
    int n_valid;
    checks   = 0;
    failures = 0;

    do_reset();
    check_reset_values("rst");

    // Basic conversion and the moving average walking CLOSE -> NEAR -> FAR.
    run("s10", 22'd29000, 10, ZONE_CLOSE);
    run("s32", 22'd290000, 32, ZONE_NEAR);
    run("s55", 22'd290000, 55, ZONE_FAR);

    // Priming at 52 from NONE lands in FAR.
    do_reset();
    run("p52", 22'd150800, 52, ZONE_FAR);

    // NEAR hysteresis: 52 stays NEAR, 55 exits to FAR.
    do_reset();
    run("h30", 22'd87000, 30, ZONE_NEAR);
    run("h52", 22'd342200, 52, ZONE_NEAR);
    run("h55", 22'd121800, 55, ZONE_FAR);

    // Saturation and division boundaries.
    do_reset();
    run("sat", 22'd4194303, 400, ZONE_FAR);
    do_reset();
    run("d399", 22'd1159999, 399, ZONE_FAR);
    do_reset();
    run("d0", 22'd0, 0, ZONE_CLOSE);
    run("d4", 22'd11600, 1, ZONE_CLOSE);

    // Entry thresholds are strict.
    do_reset();
    run("e50", 22'd145000, 50, ZONE_FAR);
    do_reset();
    run("e20", 22'd58000, 20, ZONE_NEAR);
    do_reset();
    run("e19", 22'd57999, 19, ZONE_CLOSE);

    // Stale timeout, then reprime from scratch.
    do_reset();
    run("st10", 22'd29000, 10, ZONE_CLOSE);
    repeat (245) @(negedge clk);
    check("stale_early", 32'(ifc.stale), 32'd0);
    repeat (35) @(negedge clk);
    check("stale_set", 32'(ifc.stale), 32'd1);
    check("stale_zone", 32'(ifc.zone), 32'd3);
    check("stale_hold_cm", 32'(ifc.dist_cm), 32'd10);
    run("st30", 22'd87000, 30, ZONE_NEAR);

    // Strobe while busy is dropped: one result, from the first sample.
    do_reset();
    send(22'd29000);
    repeat (4) @(negedge clk);
    ifc.sample_valid = 1'b1;
    ifc.distance_raw = 22'd290000;
    @(negedge clk);
    ifc.sample_valid = 1'b0;
    n_valid = 0;
    for (int i = 0; i < 60; i++) begin
      if (ifc.dist_valid) n_valid++;
      @(negedge clk);
    end
    check("ign.count", 32'(n_valid), 32'd1);
    check("ign.dist_cm", 32'(ifc.dist_cm), 32'd10);

    // Asynchronous reset mid-conversion aborts without a result.
    send(22'd290000);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_valid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ifc.dist_valid) n_valid++;
    end
    check("abort.count", 32'(n_valid), 32'd0);
    check("abort.busy", 32'(ifc.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/distance_tracker.md
# distance_tracker

Consumes raw echo-width samples from the proximity sensor (`ready` strobe plus 22-bit `distanceRAW`, in 50 MHz clock cycles) and converts them to centimetres. Smooths the result with a 4-sample moving average and classifies it into proximity zones with hysteresis. Flags the data as stale when the sensor stops delivering samples. Sits directly downstream of `proximity_sensor`; its zone output drives LEDs and alert logic in the top level.

## Interface
- `CYCLES_PER_CM`, 2900, echo cycles per cm (50 MHz × 58 µs)
- `MAX_CM`, 400, saturation value for `dist_cm`
- `NEAR_CM`, 50, enter NEAR when average < this
- `CLOSE_CM`, 20, enter CLOSE when average < this
- `HYST_CM`, 5, exit hysteresis added to thresholds
- `STALE_CYCLES`, 25_000_000, cycles without a sample before stale (500 ms)

Ports:
- `clk`  in  1  system clock (50 MHz)
- `rst_n`  in  1  reset; asynchronous, active-low
- `sample_valid`  in  1  one-cycle strobe, connects to sensor `ready`
- `distance_raw`  in  22  echo width in clock cycles, valid with `sample_valid`
- `dist_cm`  out  9  averaged distance, cm
- `dist_valid`  out  1  one-cycle pulse when `dist_cm`/`zone` update
- `zone`  out  2  0 FAR, 1 NEAR, 2 CLOSE, 3 NONE
- `stale`  out  1  no recent data
- `busy`  out  1  conversion in progress; samples ignored

## Operation
- FSM states:
  - IDLE: waits for a sample.
  - DIV: runs 22 restoring-division iterations, one per cycle.
  - AVG: updates the averager.
  - OUT: classifies the zone and pulses `dist_valid`.
- IDLE + `sample_valid`: latch `distance_raw`, go to DIV.
- Division:
  - quotient = floor(`distance_raw` / `CYCLES_PER_CM`), unsigned, truncating.
  - If quotient > `MAX_CM`, use `MAX_CM`.
  - Raw 0 gives 0.
- Averager:
  - 4-entry ring buffer of 9-bit values with an 11-bit running sum.
  - New sum = sum − oldest + new; `dist_cm` = sum >> 2 (truncate).
  - When the buffer is not primed (after reset or after stale), the first sample fills all 4 entries and sets the primed flag.
- Zone update, evaluated once per result with avg = new `dist_cm`:
  - NONE or FAR: avg < `CLOSE_CM` → CLOSE; avg < `NEAR_CM` → NEAR; otherwise FAR.
  - NEAR: avg < `CLOSE_CM` → CLOSE; avg ≥ `NEAR_CM`+`HYST_CM` → FAR; otherwise NEAR.
  - CLOSE: avg ≥ `NEAR_CM`+`HYST_CM` → FAR; avg ≥ `CLOSE_CM`+`HYST_CM` → NEAR; otherwise CLOSE.
- Stale timer:
  - Counts every cycle and resets to 0 on any `sample_valid`, whether accepted or ignored.
  - When the count reaches `STALE_CYCLES`: `stale` = 1, `zone` = NONE, primed flag cleared. `dist_cm` holds its last value and the counter saturates.
  - The next accepted sample's OUT cycle clears `stale`.
- `sample_valid` while `busy`: ignored; no queueing and no second result.
- If the stale timeout and OUT fall in the same cycle, OUT wins and the timer restarts.

## Timing
- Reset values: `dist_cm` 0, `dist_valid` 0, `zone` 3 (NONE), `stale` 1, `busy` 0. FSM in IDLE, primed flag 0, buffer and sum 0, timer 0.
- Sample accepted at cycle 0:
  - `busy` = 1 in cycles 1–24.
  - DIV occupies cycles 1–22.
  - AVG occupies cycle 23.
  - `dist_valid`, `dist_cm`, `zone` and `stale` update together in cycle 24.
  - Latency: 24 cycles.
- `busy` falls at cycle 25; a sample at cycle 25 is accepted.
- `rst_n` asserted mid-conversion: everything returns to reset values immediately, and no `dist_valid` is produced for the aborted sample.
- `dist_valid` is never high for two consecutive cycles.

## Structure
- Shared package `proximity_pkg`:
  - `zone_t` enum (FAR, NEAR, CLOSE, NONE).
  - `RAW_W` = 22, `CM_W` = 9.
  - Default threshold constants.
- Sub-module `seq_divider`:
  - Unsigned restoring divider, parameterised widths.
  - Handshake: start/done, one iteration per cycle.
  - Instantiated once.
- Averager and zone FSM live in `distance_tracker`.

## Test plan
- After reset, raw 29000 → `dist_valid` at cycle 24 with `dist_cm` 10, `zone` CLOSE, `stale` 0.
- Then two samples of raw 290000 → first result `dist_cm` 32, `zone` NEAR; second result `dist_cm` 55, `zone` FAR.
- Hysteresis: prime at 52 cm from FAR → FAR. From NEAR, an average of 52 stays NEAR and an average of 55 → FAR.
- Raw 4194303 → `dist_cm` 400 (saturated).
- No samples for 25_000_000 cycles → `stale` 1, `zone` NONE. Next raw 87000 primes to 30 → `zone` NEAR, `stale` 0.
- Second `sample_valid` at cycle 5 → ignored, exactly one `dist_valid`. `rst_n` low at cycle 10 of a conversion → reset values, no `dist_valid`.
